// File: rtl/alu_result_checker.sv
// alu_result_checker: two-stage checker of observed ALU vectors; define ALU_CHK_ZERO_EN to also compare the Zero flag
module alu_result_checker #(
  parameter int VEC_COUNT = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [2:0]       ALU_Sel,
  input  logic [7:0]       ALU_Out,
  input  logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [15:0]      first_fail_idx,
  output logic [7:0]       first_fail_exp,
  output logic             any_fail
);
`ifdef ALU_CHK_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
  localparam logic [15:0] LAST = 16'(VEC_COUNT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic drain_q, drain_d;
  logic [15:0] idx_q, idx_d;
  logic v1_q, expz_q, zero_q;
  logic [7:0] exp_q, out_q;
  logic [15:0] idx1_q;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic [15:0] ffi_q, ffi_d;
  logic [7:0] ffe_q, ffe_d, exp_c;
  logic any_q, any_d;
  logic accept, clr, match, pass_inc, fail_inc;
  // reference result of the opcode, wrapped to 8 bits
  always_comb begin
    exp_c = ALU_Sel == 3'd0 ? A + B :
            ALU_Sel == 3'd1 ? A - B :
            ALU_Sel == 3'd2 ? A & B :
            ALU_Sel == 3'd3 ? A | B :
            ALU_Sel == 3'd4 ? A ^ B :
            ALU_Sel == 3'd5 ? A << 1 :
            ALU_Sel == 3'd6 ? A >> 1 : A;
  end
  // FSM next state, acceptance index and stage-2 result bookkeeping
  always_comb begin
    accept = in_valid && state_q == RUN;
    clr = start && (state_q == IDLE || state_q == DONE);
    match = out_q == exp_q && (!ZERO_EN || zero_q == expz_q);
    pass_inc = v1_q && match && !(&pass_q);
    fail_inc = v1_q && !match && !(&fail_q);
    state_d = clr ? RUN :
              (accept && idx_q == LAST) ? DRAIN :
              (state_q == DRAIN && drain_q) ? DONE : state_q;
    drain_d = state_q == DRAIN && !drain_q;
    idx_d = clr ? 16'd0 : accept ? idx_q + 16'd1 : idx_q;
    pass_d = clr ? '0 : pass_inc ? pass_q + CNT_W'(1) : pass_q;
    fail_d = clr ? '0 : fail_inc ? fail_q + CNT_W'(1) : fail_q;
    ffi_d = clr ? 16'd0 : (v1_q && !match && !any_q) ? idx1_q : ffi_q;
    ffe_d = clr ? 8'd0 : (v1_q && !match && !any_q) ? exp_q : ffe_q;
    any_d = clr ? 1'b0 : any_q || (v1_q && !match);
  end
  // control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      idx_q <= 16'd0;
      pass_q <= '0;
      fail_q <= '0;
      ffi_q <= 16'd0;
      ffe_q <= 8'd0;
      any_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      idx_q <= idx_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ffi_q <= ffi_d;
      ffe_q <= ffe_d;
      any_q <= any_d;
    end
  end
  // stage 1: capture the accepted vector with its expected result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      exp_q <= 8'd0;
      expz_q <= 1'b0;
      out_q <= 8'd0;
      zero_q <= 1'b0;
      idx1_q <= 16'd0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        exp_q <= exp_c;
        expz_q <= exp_c == 8'd0;
        out_q <= ALU_Out;
        zero_q <= Zero;
        idx1_q <= idx_q;
      end
    end
  end
  assign in_ready = state_q == RUN;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_exp = ffe_q;
  assign any_fail = any_q;
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: randomized scoreboard bench for alu_result_checker
module tb_alu_result_checker;
  localparam int N = 9;
  localparam int CW = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, Zero = 1'b0;
  logic [7:0] A = 8'd0, B = 8'd0, ALU_Out = 8'd0;
  logic [2:0] ALU_Sel = 3'd0;
  logic in_ready, busy, done, any_fail;
  logic [CW-1:0] pass_count, fail_count;
  logic [15:0] first_fail_idx;
  logic [7:0] first_fail_exp;
  typedef struct {logic [7:0] a, b, out; logic [2:0] sel; logic z;} vec_t;
  typedef struct {int p, f, ffi, ffe; bit any; longint acc;} exp_t;
  vec_t vecs[N];
  exp_t sbq[$];
  int n_chk = 0, n_fail = 0, rdy_cnt = 0, prev_sum = 0, cur_sum;
  int m_p, m_f, m_ffi, m_ffe;
  bit m_any;
  longint cyc = 0;
  exp_t me;

  alu_result_checker #(.VEC_COUNT(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .Zero(Zero),
    .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp), .any_fail(any_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (in_ready) rdy_cnt <= rdy_cnt + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int sel);
    case (sel)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a * 2) % 256;
      6: return a / 2;
      default: return a;
    endcase
  endfunction

  // monitor: each one-step rise of the combined count retires the oldest expectation
  always @(negedge clk) if (!rst) begin
    cur_sum = int'(pass_count) + int'(fail_count);
    if (cur_sum == 0) prev_sum = 0;
    else if (cur_sum != prev_sum) begin
      if (cur_sum == prev_sum + 1 && sbq.size() > 0) begin
        me = sbq.pop_front();
        chk("sb_pass", pass_count, me.p);
        chk("sb_fail", fail_count, me.f);
        chk("sb_any", any_fail, me.any);
        chk("sb_ffi", first_fail_idx, me.ffi);
        chk("sb_ffe", first_fail_exp, me.ffe);
        chk("sb_latency", cyc, me.acc + 1);
      end else chk("spurious_update", cur_sum, prev_sum);
      prev_sum = cur_sum;
    end
  end

  task automatic send(input vec_t v, input int idx);
    int t = 0;
    int ev;
    bit ok;
    exp_t e;
    in_valid = 1'b1; A = v.a; B = v.b; ALU_Sel = v.sel; ALU_Out = v.out; Zero = v.z;
    while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("accept_timeout", in_ready, 1);
    else begin
      ev = ref_alu(v.a, v.b, v.sel);
      ok = int'(v.out) == ev;
`ifdef ALU_CHK_ZERO_EN
      ok = ok && (v.z == (ev == 0));
`endif
      if (ok) m_p++; else m_f++;
      if (!ok && !m_any) begin m_any = 1; m_ffi = idx; m_ffe = ev; end
      e.p = m_p; e.f = m_f; e.any = m_any; e.ffi = m_ffi; e.ffe = m_ffe; e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    rdy_cnt = 0;
    m_p = 0; m_f = 0; m_ffi = 0; m_ffe = 0; m_any = 0;
    @(negedge clk);
    start = 1'b0;
    chk("clr_pass", pass_count, 0);
    chk("clr_fail", fail_count, 0);
    chk("clr_any", any_fail, 0);
    chk("clr_ffi", first_fail_idx, 0);
    chk("start_busy", busy, 1);
  endtask

  task automatic run(input bit gaps, input bit ign);
    do_start();
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (ign && i == 4) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_ready", in_ready, 1);
        chk("ign_pass", pass_count, m_p);
      end
      send(vecs[i], i);
    end
    chk("done_lag0", done, 0);
    @(negedge clk);
    chk("done_lag1", done, 0);
    @(negedge clk);
    chk("done_lag2", done, 1);
    chk("end_busy", busy, 0);
    chk("end_ready", in_ready, 0);
    chk("end_pass", pass_count, m_p);
    chk("end_fail", fail_count, m_f);
    chk("end_any", any_fail, m_any);
    chk("end_ffi", first_fail_idx, m_ffi);
    chk("end_ffe", first_fail_exp, m_ffe);
    chk("sb_empty", sbq.size(), 0);
    if (!gaps && !ign) chk("rdy_cycles", rdy_cnt, N);
  endtask

  task automatic load_dir();
    logic [7:0] outs[N] = '{8'h0F, 8'h05, 8'h00, 8'h0F, 8'h0F, 8'h14, 8'h05, 8'h0A, 8'h00};
    for (int i = 0; i < N; i++) begin
      vecs[i].a = (i == 8) ? 8'h00 : 8'h0A;
      vecs[i].b = (i == 8) ? 8'h00 : 8'h05;
      vecs[i].sel = (i == 8) ? 3'd0 : 3'(i);
      vecs[i].out = outs[i];
      vecs[i].z = outs[i] == 8'h00;
    end
  endtask

  task automatic load_rand();
    int e;
    for (int i = 0; i < N; i++) begin
      vecs[i].a = 8'($urandom);
      vecs[i].b = ($urandom_range(0, 3) == 0) ? vecs[i].a : 8'($urandom);
      vecs[i].sel = 3'($urandom);
      e = ref_alu(vecs[i].a, vecs[i].b, vecs[i].sel);
      vecs[i].out = ($urandom_range(0, 3) == 0) ? 8'(e ^ $urandom_range(1, 255)) : 8'(e);
      vecs[i].z = (e == 0) ^ ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_ready"}, in_ready, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass_count, 0);
    chk({nm, "_fail"}, fail_count, 0);
    chk({nm, "_ffi"}, first_fail_idx, 0);
    chk({nm, "_ffe"}, first_fail_exp, 0);
    chk({nm, "_any"}, any_fail, 0);
  endtask

  initial begin
    #1 chk_zero_outputs("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_dir();
    run(0, 0);
    chk("dir_pass", pass_count, 9);
    chk("dir_fail", fail_count, 0);
    load_dir();
    vecs[3].out = 8'h0E;
    run(0, 0);
    chk("err_fail", fail_count, 1);
    chk("err_ffi", first_fail_idx, 3);
    chk("err_ffe", first_fail_exp, 8'h0F);
    load_dir();
    vecs[8].z = 1'b0;
    run(1, 0);
`ifdef ALU_CHK_ZERO_EN
    chk("zflag_fail", fail_count, 1);
`else
    chk("zflag_pass", pass_count, 9);
`endif
    load_dir();
    vecs[6].out = 8'h07;
    run(0, 1);
    load_dir();
    do_start();
    for (int i = 0; i < 4; i++) send(vecs[i], i);
    rst = 1'b1;
    #1 chk_zero_outputs("midrst");
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("postrst");
    run(0, 0);
    chk("rst_pass", pass_count, 9);
    for (int r = 0; r < 15; r++) begin
      load_rand();
      run(r % 2 == 1, r == 6);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
